// File: rtl/serial_port_if.sv
// COM window between the physical memory controller (master) and the UART (slave).
interface serial_port_if;
   logic       enable_com_write;
   logic [7:0] com_data_out;
   logic       int_com_ack;
   logic [7:0] com_data_in;
   logic       com_read_ready;
   logic       com_write_ready;
   logic       rx_overrun;
   logic       rx_frame_err;

   modport master (
      output enable_com_write, com_data_out, int_com_ack,
      input  com_data_in, com_read_ready, com_write_ready, rx_overrun, rx_frame_err
   );

   modport slave (
      input  enable_com_write, com_data_out, int_com_ack,
      output com_data_in, com_read_ready, com_write_ready, rx_overrun, rx_frame_err
   );
endinterface

// File: rtl/serial_port.sv
// 8N1 UART transceiver behind the COM window; define SERIAL_RX_FIFO_EN for a
// 2**RX_FIFO_AW entry RX FIFO instead of a single holding register.
module serial_port #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 115200,
   parameter int RX_FIFO_AW = 4
) (
   input  logic         clk50M,
   input  logic         rst,
   serial_port_if.slave bus,
   input  logic         rxd,
   output logic         txd
);
   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   if (RX_FIFO_AW < 1 || CLKS_PER_BIT < 2) begin : g_param_check
      $error("serial_port: need RX_FIFO_AW >= 1 and CLK_FREQ/BAUD >= 2");
   end

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   tx_state_t        tx_state, tx_state_next;
   logic [CNT_W-1:0] tx_cnt;
   logic [2:0]       tx_idx;
   logic [7:0]       tx_shift;
   logic             tx_bit_end;

   assign tx_bit_end          = (tx_cnt == BIT_LAST);
   assign bus.com_write_ready = (tx_state == TX_IDLE);

   always_comb begin
      tx_state_next = tx_state;
      txd           = 1'b1;
      case (tx_state)
         TX_IDLE:  if (bus.enable_com_write) tx_state_next = TX_START;
         TX_START: begin
            txd = 1'b0;
            if (tx_bit_end) tx_state_next = TX_DATA;
         end
         TX_DATA: begin
            txd = tx_shift[0];
            if (tx_bit_end && tx_idx == 3'd7) tx_state_next = TX_STOP;
         end
         TX_STOP:  if (tx_bit_end) tx_state_next = TX_IDLE;
         default:  tx_state_next = TX_IDLE;
      endcase
   end

   // Strobes arriving outside IDLE are simply not latched.
   always_ff @(posedge clk50M) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         tx_shift <= '0;
      end else begin
         tx_state <= tx_state_next;
         if (tx_state == TX_IDLE || tx_bit_end) tx_cnt <= '0;
         else                                   tx_cnt <= tx_cnt + 1'b1;
         if (tx_state == TX_IDLE) begin
            tx_idx <= '0;
            if (bus.enable_com_write) tx_shift <= bus.com_data_out;
         end else if (tx_state == TX_DATA && tx_bit_end) begin
            tx_idx   <= tx_idx + 1'b1;
            tx_shift <= {1'b0, tx_shift[7:1]};
         end
      end
   end

   rx_state_t        rx_state, rx_state_next;
   logic [1:0]       rx_sync;
   logic             rx_line;
   logic [CNT_W-1:0] rx_cnt;
   logic [2:0]       rx_idx;
   logic [7:0]       rx_shift;
   logic             rx_sample, push, frame_bad;

   assign rx_line   = rx_sync[1];
   assign rx_sample = (rx_state == RX_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == BIT_LAST);

   // The start bit is re-checked at mid-bit so short low glitches are rejected.
   always_comb begin
      rx_state_next = rx_state;
      push          = 1'b0;
      frame_bad     = 1'b0;
      case (rx_state)
         RX_IDLE:  if (!rx_line) rx_state_next = RX_START;
         RX_START: if (rx_sample) rx_state_next = rx_line ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_sample && rx_idx == 3'd7) rx_state_next = RX_STOP;
         RX_STOP: begin
            if (rx_sample) begin
               rx_state_next = RX_IDLE;
               push          = rx_line;
               frame_bad     = !rx_line;
            end
         end
         default:  rx_state_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk50M) begin
      if (rst) begin
         rx_sync  <= 2'b11;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_idx   <= '0;
         rx_shift <= '0;
      end else begin
         rx_sync  <= {rx_sync[0], rxd};
         rx_state <= rx_state_next;
         if (rx_state == RX_IDLE || rx_sample) rx_cnt <= '0;
         else                                  rx_cnt <= rx_cnt + 1'b1;
         if (rx_state != RX_DATA) begin
            rx_idx <= '0;
         end else if (rx_sample) begin
            rx_idx   <= rx_idx + 1'b1;
            rx_shift <= {rx_line, rx_shift[7:1]};
         end
      end
   end

   logic ack_q, pop, push_drop;
   assign pop = bus.int_com_ack && !ack_q;

   always_ff @(posedge clk50M) begin
      if (rst) begin
         ack_q            <= 1'b0;
         bus.rx_frame_err <= 1'b0;
         bus.rx_overrun   <= 1'b0;
      end else begin
         ack_q <= bus.int_com_ack;
         if (frame_bad) bus.rx_frame_err <= 1'b1;
         if (push_drop) bus.rx_overrun   <= 1'b1;
      end
   end

`ifdef SERIAL_RX_FIFO_EN
   localparam int DEPTH = 2 ** RX_FIFO_AW;

   logic [7:0]            fifo_mem [DEPTH];
   logic [RX_FIFO_AW-1:0] rd_ptr, wr_ptr;
   logic [RX_FIFO_AW:0]   count, count_popped;
   logic [7:0]            head;
   logic                  pop_ok, push_ok;

   // Pop is applied first, so a full FIFO still takes a push in the same cycle.
   assign pop_ok       = pop && (count != '0);
   assign count_popped = count - (RX_FIFO_AW+1)'(pop_ok);
   assign push_ok      = push && (count_popped != (RX_FIFO_AW+1)'(DEPTH));
   assign push_drop    = push && !push_ok;

   always_ff @(posedge clk50M) begin
      if (push_ok) fifo_mem[wr_ptr] <= rx_shift;
   end

   always_ff @(posedge clk50M) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_popped + (RX_FIFO_AW+1)'(push_ok);
         if (count_popped == '0) begin
            if (push_ok) head <= rx_shift;
         end else if (pop_ok) begin
            head <= fifo_mem[rd_ptr + 1'b1];
         end
      end
   end

   assign bus.com_data_in    = head;
   assign bus.com_read_ready = (count != '0);
`else
   logic [7:0] hold_data;
   logic       hold_valid, hold_room;

   assign hold_room = !hold_valid || pop;
   assign push_drop = push && !hold_room;

   always_ff @(posedge clk50M) begin
      if (rst) begin
         hold_data  <= '0;
         hold_valid <= 1'b0;
      end else if (push && hold_room) begin
         hold_data  <= rx_shift;
         hold_valid <= 1'b1;
      end else if (pop) begin
         hold_valid <= 1'b0;
      end
   end

   assign bus.com_data_in    = hold_data;
   assign bus.com_read_ready = hold_valid;
`endif
endmodule

// File: tb/tb_serial_port.sv
// Directed bench for serial_port at CLKS_PER_BIT=10; covers both SERIAL_RX_FIFO_EN builds.
module tb_serial_port;
   localparam int CPB   = 10;
   localparam int DEPTH = 16;

   typedef struct {
      logic [7:0] rx_byte;
      logic       stop_bit;
      logic       exp_ready;
      logic [7:0] exp_data;
      logic       exp_frame_err;
      logic       pop_after;
   } rx_vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rxd = 1'b1;
   logic txd;
   int   checks = 0;
   int   errors = 0;
   rx_vec_t vecs [3];

   serial_port_if bus();

   serial_port #(.CLK_FREQ(1000), .BAUD(100), .RX_FIFO_AW(4)) dut (
      .clk50M(clk),
      .rst(rst),
      .bus(bus),
      .rxd(rxd),
      .txd(txd)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Called on a negedge; returns on a negedge after the line has idled one bit time.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic ack_at_push);
      logic [9:0] frame;
      frame = {stop_bit, b, 1'b0};
      fork
         begin
            for (int k = 0; k < 10; k++) begin
               rxd = frame[k];
               repeat (CPB) @(negedge clk);
            end
            rxd = 1'b1;
            repeat (CPB) @(negedge clk);
         end
         begin
            if (ack_at_push) begin
               repeat (97) @(negedge clk);
               bus.int_com_ack = 1'b1;
               repeat (2) @(negedge clk);
               bus.int_com_ack = 1'b0;
            end
         end
      join
   endtask

   task automatic pop_byte();
      bus.int_com_ack = 1'b1;
      @(negedge clk);
      bus.int_com_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic apply_stimulus(input rx_vec_t vec);
      send_frame(vec.rx_byte, vec.stop_bit, 1'b0);
      check_output("rx_ready", 16'(bus.com_read_ready), 16'(vec.exp_ready));
      check_output("rx_data", 16'(bus.com_data_in), 16'(vec.exp_data));
      check_output("frame_err", 16'(bus.rx_frame_err), 16'(vec.exp_frame_err));
      check_output("overrun", 16'(bus.rx_overrun), 16'd0);
      if (vec.pop_after) begin
         bus.int_com_ack = 1'b1;
         repeat (3) @(negedge clk);
         bus.int_com_ack = 1'b0;
         @(negedge clk);
         check_output("ready_after_pop", 16'(bus.com_read_ready), 16'd0);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check_output({tag, "_txd"}, 16'(txd), 16'd1);
      check_output({tag, "_wr_ready"}, 16'(bus.com_write_ready), 16'd1);
      check_output({tag, "_rd_ready"}, 16'(bus.com_read_ready), 16'd0);
      check_output({tag, "_data"}, 16'(bus.com_data_in), 16'd0);
      check_output({tag, "_overrun"}, 16'(bus.rx_overrun), 16'd0);
      check_output({tag, "_frame_err"}, 16'(bus.rx_frame_err), 16'd0);
   endtask

   initial begin
      logic [9:0] tx_frame;
      vecs[0] = '{rx_byte: 8'h3C, stop_bit: 1'b1, exp_ready: 1'b1, exp_data: 8'h3C, exp_frame_err: 1'b0, pop_after: 1'b1};
      vecs[1] = '{rx_byte: 8'hC3, stop_bit: 1'b1, exp_ready: 1'b1, exp_data: 8'hC3, exp_frame_err: 1'b0, pop_after: 1'b1};
      vecs[2] = '{rx_byte: 8'h55, stop_bit: 1'b0, exp_ready: 1'b0, exp_data: 8'hC3, exp_frame_err: 1'b1, pop_after: 1'b0};

      bus.enable_com_write = 1'b0;
      bus.com_data_out     = 8'h00;
      bus.int_com_ack      = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_state("reset");
      rst = 1'b0;
      @(negedge clk);

      // Transmit 0xA5 with a second strobe mid-frame that must be ignored.
      tx_frame = {1'b1, 8'hA5, 1'b0};
      bus.enable_com_write = 1'b1;
      bus.com_data_out     = 8'hA5;
      @(negedge clk);
      bus.enable_com_write = 1'b0;
      for (int i = 0; i < 10 * CPB; i++) begin
         check_output("tx_bit", 16'(txd), 16'(tx_frame[i / CPB]));
         check_output("tx_busy", 16'(bus.com_write_ready), 16'd0);
         bus.enable_com_write = (i == 50);
         bus.com_data_out     = (i == 50) ? 8'hFF : 8'hA5;
         @(negedge clk);
      end
      check_output("tx_ready_back", 16'(bus.com_write_ready), 16'd1);
      for (int i = 0; i < 2 * CPB; i++) begin
         @(negedge clk);
         check_output("tx_idle_line", 16'(txd), 16'd1);
      end

      // Three-cycle low pulse on rxd is a glitch, not a start bit.
      rxd = 1'b0;
      repeat (3) @(negedge clk);
      rxd = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      check_output("glitch_ready", 16'(bus.com_read_ready), 16'd0);
      check_output("glitch_frame_err", 16'(bus.rx_frame_err), 16'd0);

      for (int v = 0; v < 3; v++) apply_stimulus(vecs[v]);
      repeat (2 * CPB) @(negedge clk);

`ifdef SERIAL_RX_FIFO_EN
      for (int i = 0; i < DEPTH; i++) send_frame(8'h40 + 8'(i), 1'b1, 1'b0);
      check_output("fifo_full_ready", 16'(bus.com_read_ready), 16'd1);
      check_output("fifo_full_head", 16'(bus.com_data_in), 16'h40);
      send_frame(8'h60, 1'b1, 1'b1);
      check_output("collide_overrun", 16'(bus.rx_overrun), 16'd0);
      for (int i = 0; i < DEPTH; i++) begin
         check_output("collide_drain", 16'(bus.com_data_in), (i == DEPTH - 1) ? 16'h60 : 16'h41 + 16'(i));
         pop_byte();
      end
      check_output("collide_empty", 16'(bus.com_read_ready), 16'd0);

      for (int i = 0; i <= DEPTH; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0);
      check_output("fifo_overrun", 16'(bus.rx_overrun), 16'd1);
      for (int i = 0; i < DEPTH; i++) begin
         check_output("fifo_ready", 16'(bus.com_read_ready), 16'd1);
         check_output("fifo_drain", 16'(bus.com_data_in), 16'h10 + 16'(i));
         pop_byte();
      end
      check_output("fifo_empty", 16'(bus.com_read_ready), 16'd0);
`else
      send_frame(8'h77, 1'b1, 1'b0);
      check_output("hold_data", 16'(bus.com_data_in), 16'h77);
      send_frame(8'h88, 1'b1, 1'b1);
      check_output("collide_ready", 16'(bus.com_read_ready), 16'd1);
      check_output("collide_data", 16'(bus.com_data_in), 16'h88);
      check_output("collide_overrun", 16'(bus.rx_overrun), 16'd0);
      pop_byte();
      check_output("collide_empty", 16'(bus.com_read_ready), 16'd0);

      send_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0);
      check_output("overrun_ready", 16'(bus.com_read_ready), 16'd1);
      check_output("overrun_data", 16'(bus.com_data_in), 16'h11);
      check_output("overrun_flag", 16'(bus.rx_overrun), 16'd1);
`endif

      // Reset in the middle of a transmission clears everything, sticky flags included.
      bus.enable_com_write = 1'b1;
      bus.com_data_out     = 8'h00;
      @(negedge clk);
      bus.enable_com_write = 1'b0;
      repeat (35) @(negedge clk);
      check_output("mid_tx_line", 16'(txd), 16'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_state("reset2");
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_output("post_reset_txd", 16'(txd), 16'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
